// File: rtl/multi_lane_hit_cnt.sv
// Per-triangle hit/sample counter: folds LANES qualified samples per cycle into
// the open triangle and queues a {id, hits, samps, sat} record when it closes.

module mlhc_lane (
  input  logic samp_i,
  input  logic hit_i,
  output logic qhit_o
);
  // a hit only counts on a lane that was actually tested
  assign qhit_o = samp_i & hit_i;
endmodule

module multi_lane_hit_cnt #(
  parameter int SIGFIG = 24,
  parameter int LANES  = 2,
  parameter int ID_W   = 16,
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tri_valid_R,
  input  logic [ID_W-1:0]   tri_id_R,
  input  logic [LANES-1:0]  samp_valid_R,
  input  logic [LANES-1:0]  hit_valid_R,
  input  logic              flush_R,
  output logic              rec_valid_R,
  input  logic              rec_ready_R,
  output logic [ID_W-1:0]   rec_id_R,
  output logic [CNT_W-1:0]  rec_hits_R,
  output logic [CNT_W-1:0]  rec_samps_R,
  output logic              rec_sat_R,
  output logic              drop_R
);
  localparam bit PARAMS_OK = (SIGFIG > 0) && (LANES >= 1) && (LANES <= 8) &&
                             (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);
  if (!PARAMS_OK) begin : g_bad_params
    $error("multi_lane_hit_cnt: illegal parameter set");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OPEN = 1'b1;
  localparam int PW = $clog2(DEPTH);
  // sum width leaves headroom for one cycle's popcount (<= 8) above the max
  localparam int SW = CNT_W + 4;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] samps;
    logic             sat;
  } rec_t;

  // lane qualification
  logic [LANES-1:0] qhit;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mlhc_lane u_lane (
      .samp_i (samp_valid_R[i]),
      .hit_i  (hit_valid_R[i]),
      .qhit_o (qhit[i])
    );
  end

  logic [3:0] hit_pc, samp_pc;
  always_comb begin
    hit_pc  = '0;
    samp_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_pc  = hit_pc + 4'(qhit[i]);
      samp_pc = samp_pc + 4'(samp_valid_R[i]);
    end
  end

  // accumulator state
  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [CNT_W-1:0] hit_acc_q, hit_acc_d;
  logic [CNT_W-1:0] samp_acc_q, samp_acc_d;
  logic             sat_q, sat_d;

  logic          cont, close;
  logic [SW-1:0] hit_sum, samp_sum;
  logic          hit_ovf, samp_ovf;

  // same-triangle continuation adds onto the accumulators, anything else reloads
  assign cont     = (state_q == OPEN) && (tri_id_R == cur_id_q);
  assign hit_sum  = (cont ? SW'(hit_acc_q)  : '0) + SW'(hit_pc);
  assign samp_sum = (cont ? SW'(samp_acc_q) : '0) + SW'(samp_pc);
  assign hit_ovf  = hit_sum > CMAX;
  assign samp_ovf = samp_sum > CMAX;

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    hit_acc_d  = hit_acc_q;
    samp_acc_d = samp_acc_q;
    sat_d      = sat_q;
    close      = 1'b0;
    if (tri_valid_R) begin
      close      = (state_q == OPEN) && !cont;
      state_d    = OPEN;
      cur_id_d   = tri_id_R;
      hit_acc_d  = hit_ovf  ? CMAX[CNT_W-1:0] : hit_sum[CNT_W-1:0];
      samp_acc_d = samp_ovf ? CMAX[CNT_W-1:0] : samp_sum[CNT_W-1:0];
      sat_d      = (cont & sat_q) | hit_ovf | samp_ovf;
    end else if (flush_R && (state_q == OPEN)) begin
      close   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      hit_acc_q  <= '0;
      samp_acc_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      hit_acc_q  <= hit_acc_d;
      samp_acc_q <= samp_acc_d;
      sat_q      <= sat_d;
    end
  end

  // record FIFO; pointers carry an extra wrap bit to tell full from empty
  rec_t          mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          drop_q, drop_d;
  logic          empty, full, push, pop;
  rec_t          close_rec, head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                     (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign pop       = !empty && rec_ready_R;
  assign push      = close && (!full || pop);
  assign close_rec = '{cur_id_q, hit_acc_q, samp_acc_q, sat_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q | (close & full & !pop);
    if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // storage needs no reset: outputs are gated while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q[PW-1:0]] <= close_rec;
  end

  assign head        = mem_q[rd_ptr_q[PW-1:0]];
  assign rec_valid_R = !empty;
  assign rec_id_R    = empty ? '0 : head.id;
  assign rec_hits_R  = empty ? '0 : head.hits;
  assign rec_samps_R = empty ? '0 : head.samps;
  assign rec_sat_R   = empty ? 1'b0 : head.sat;
  assign drop_R      = drop_q;
endmodule

// File: tb/tb_multi_lane_hit_cnt.sv
// Bench for multi_lane_hit_cnt: two instances (CNT_W=16 and CNT_W=4) share one
// stimulus stream and one reference queue of unclamped per-triangle totals.
module tb_multi_lane_hit_cnt;
  localparam int LANES = 2;
  localparam int ID_W  = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, tri_valid, flush, rdy;
  logic [ID_W-1:0]  tri_id;
  logic [LANES-1:0] samp, hit;

  logic             rv_a, sat_a, drop_a, rv_b, sat_b, drop_b;
  logic [ID_W-1:0]  id_a, id_b;
  logic [15:0]      hits_a, samps_a;
  logic [3:0]       hits_b, samps_b;

  always #5 clk = ~clk;

  multi_lane_hit_cnt #(.SIGFIG(24), .LANES(LANES), .ID_W(ID_W), .CNT_W(16), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .tri_valid_R(tri_valid), .tri_id_R(tri_id),
    .samp_valid_R(samp), .hit_valid_R(hit), .flush_R(flush),
    .rec_valid_R(rv_a), .rec_ready_R(rdy), .rec_id_R(id_a), .rec_hits_R(hits_a),
    .rec_samps_R(samps_a), .rec_sat_R(sat_a), .drop_R(drop_a));

  multi_lane_hit_cnt #(.SIGFIG(24), .LANES(LANES), .ID_W(ID_W), .CNT_W(4), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .tri_valid_R(tri_valid), .tri_id_R(tri_id),
    .samp_valid_R(samp), .hit_valid_R(hit), .flush_R(flush),
    .rec_valid_R(rv_b), .rec_ready_R(rdy), .rec_id_R(id_b), .rec_hits_R(hits_b),
    .rec_samps_R(samps_b), .rec_sat_R(sat_b), .drop_R(drop_b));

  // reference model: open triangle with true (unclamped) totals, queue of closed ones
  typedef struct { int id; int h; int s; } mrec_t;
  mrec_t q[$];
  bit    m_open, m_drop;
  int    m_id, m_h, m_s;
  int    nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] clampv(input int v, input int mx);
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic check_out();
    chk("valid_a", rv_a, q.size() != 0);
    chk("valid_b", rv_b, q.size() != 0);
    if (q.size() != 0) begin
      chk("id_a",    id_a,    64'(q[0].id));
      chk("hits_a",  hits_a,  clampv(q[0].h, 65535));
      chk("samps_a", samps_a, clampv(q[0].s, 65535));
      chk("sat_a",   sat_a,   (q[0].h > 65535) || (q[0].s > 65535));
      chk("id_b",    id_b,    64'(q[0].id));
      chk("hits_b",  hits_b,  clampv(q[0].h, 15));
      chk("samps_b", samps_b, clampv(q[0].s, 15));
      chk("sat_b",   sat_b,   (q[0].h > 15) || (q[0].s > 15));
    end
    chk("drop_a", drop_a, m_drop);
    chk("drop_b", drop_b, m_drop);
  endtask

  // one clock: drive, step model at the edge, check 1ns later
  task automatic cyc(input bit r, input bit tv, input int id, input logic [1:0] sv,
                     input logic [1:0] hv, input bit fl, input bit rd);
    bit    do_pop, do_close;
    mrec_t cr;
    rst = r; tri_valid = tv; tri_id = ID_W'(id); samp = sv; hit = hv; flush = fl; rdy = rd;
    @(posedge clk);
    do_pop = (q.size() != 0) && rd;
    do_close = 1'b0;
    cr = '{m_id, m_h, m_s};
    if (r) begin
      q.delete(); m_open = 0; m_drop = 0; m_h = 0; m_s = 0; m_id = 0;
    end else begin
      if (tv) begin
        if (m_open && m_id == id) begin
          m_h += $countones(hv & sv);
          m_s += $countones(sv);
        end else begin
          do_close = m_open;
          m_open = 1; m_id = id;
          m_h = $countones(hv & sv);
          m_s = $countones(sv);
        end
      end else if (fl && m_open) begin
        do_close = 1'b1;
        m_open = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (do_close) begin
        if (q.size() < DEPTH) q.push_back(cr);
        else m_drop = 1'b1;
      end
    end
    #1;
    check_out();
  endtask

  task automatic idle(input bit rd);
    cyc(0, 0, 0, 2'b00, 2'b00, 0, rd);
  endtask

  initial begin
    m_open = 0; m_drop = 0; m_id = 0; m_h = 0; m_s = 0;
    cyc(1, 0, 0, 2'b00, 2'b00, 0, 0);
    cyc(1, 1, 9, 2'b11, 2'b11, 1, 1);
    chk("rst_id",    id_a,    0);
    chk("rst_hits",  hits_a,  0);
    chk("rst_samps", samps_a, 0);
    chk("rst_sat",   sat_a,   0);

    // basic counting
    cyc(0, 1, 5, 2'b11, 2'b11, 0, 0);
    cyc(0, 1, 5, 2'b11, 2'b01, 0, 0);
    cyc(0, 1, 5, 2'b11, 2'b00, 0, 0);
    chk("basic_pending", rv_a, 0);
    idle(0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("basic_valid", rv_a, 1);
    chk("basic_hits",  hits_a, 3);
    chk("basic_samps", samps_a, 6);
    idle(1);

    // back-to-back triangles
    cyc(0, 1, 5, 2'b11, 2'b11, 0, 0);
    cyc(0, 1, 6, 2'b11, 2'b10, 0, 0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("b2b_first_id",   id_a, 5);
    chk("b2b_first_hits", hits_a, 2);
    idle(1);
    chk("b2b_second_id",   id_a, 6);
    chk("b2b_second_hits", hits_a, 1);
    idle(1);

    // masking and ignored flush
    cyc(0, 1, 7, 2'b01, 2'b11, 1, 0);
    chk("mask_no_rec", rv_a, 0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("mask_id",    id_a, 7);
    chk("mask_hits",  hits_a, 1);
    chk("mask_samps", samps_a, 1);
    idle(1);

    // backpressure and drop
    for (int k = 0; k < 5; k++) cyc(0, 1, 10 + k, 2'b11, 2'b01, 0, 0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("bp_drop", drop_a, 1);
    for (int k = 0; k < 4; k++) begin
      chk("bp_order", id_a, 64'(10 + k));
      idle(1);
    end
    chk("bp_empty", rv_a, 0);

    // saturation
    for (int k = 0; k < 9; k++) cyc(0, 1, 3, 2'b11, 2'b11, 0, 0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    chk("sat_hits_b", hits_b, 15);
    chk("sat_flag_b", sat_b, 1);
    chk("sat_hits_a", hits_a, 18);
    idle(1);

    // reset mid-triangle with records queued
    cyc(0, 1, 20, 2'b11, 2'b11, 0, 0);
    cyc(0, 1, 21, 2'b11, 2'b11, 0, 0);
    cyc(0, 1, 22, 2'b11, 2'b11, 0, 0);
    chk("rstmid_queued", rv_a, 1);
    cyc(1, 0, 0, 2'b00, 2'b00, 0, 0);
    chk("rstmid_valid", rv_a, 0);
    chk("rstmid_drop",  drop_a, 0);
    cyc(0, 0, 0, 2'b00, 2'b00, 1, 0);
    idle(0);
    chk("rstmid_no_rec", rv_a, 0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3),
          2'($urandom), 2'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 5);
    end
    for (int n = 0; n < 6; n++) idle(1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
